// File: rtl/mmio_store_if.sv
// mmio_store_if: dual-lane (EVEN/ODD) data-memory store port of the
// superscalar pipeline.
//   master : the pipeline, which drives the strobes, addresses and data
//   slave  : a snooping consumer such as mmio_store_monitor
// EVEN carries the older instruction of the pair and ODD the younger one.
interface mmio_store_if;
  logic        memwriteEVEN;
  logic [31:0] dataadrEVEN;
  logic [31:0] writedataEVEN;
  logic        memwriteODD;
  logic [31:0] dataadrODD;
  logic [31:0] writedataODD;

  modport master (
    output memwriteEVEN, dataadrEVEN, writedataEVEN,
    output memwriteODD,  dataadrODD,  writedataODD
  );

  modport slave (
    input memwriteEVEN, dataadrEVEN, writedataEVEN,
    input memwriteODD,  dataadrODD,  writedataODD
  );
endinterface

// File: rtl/mmio_store_monitor.sv
// mmio_store_monitor: snoops both store lanes every clock and decodes
// stores that fall in the memory-mapped I/O page (dataadr[31:16] == IO_PAGE).
//   offset 0x00 : LED register write  (ledr <= writedata[15:0]; ODD wins)
//   offset 0x04 : display FIFO push   (EVEN enqueued before ODD)
// A display sequencer pops each queued word and holds it on disp for
// HOLD_CYCLES clocks.
// Ports:
//   clk, reset (asynchronous, active-low), st (store port, slave side),
//   ack_ovf (clears sticky overflow), ledr, disp, disp_valid,
//   fifo_count (occupancy), overflow (sticky: a push was dropped).
module mmio_store_monitor #(
  parameter logic [15:0] IO_PAGE     = 16'hFFFF,
  parameter int          DEPTH       = 8,
  parameter int          HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  mmio_store_if.slave              st,
  input  logic                     ack_ovf,
  output logic [15:0]              ledr,
  output logic [15:0]              disp,
  output logic                     disp_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic          pop;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic hit_even, hit_odd;
  logic led_even, led_odd, push_even, push_odd;
  logic acc_even, acc_odd, drop;
  logic [CW-1:0] free;

  // Address bits below the word offset and above the 8-bit offset field
  // take no part in decode; only the low half of the data is stored.
  logic unused_bits;
  assign unused_bits = ^{st.dataadrEVEN[15:8], st.dataadrEVEN[1:0],
                         st.dataadrODD[15:8],  st.dataadrODD[1:0],
                         st.writedataEVEN[31:16], st.writedataODD[31:16]};

  assign hit_even  = st.memwriteEVEN && (st.dataadrEVEN[31:16] == IO_PAGE);
  assign hit_odd   = st.memwriteODD  && (st.dataadrODD[31:16]  == IO_PAGE);
  assign led_even  = hit_even && (st.dataadrEVEN[7:2] == 6'd0);
  assign led_odd   = hit_odd  && (st.dataadrODD[7:2]  == 6'd0);
  assign push_even = hit_even && (st.dataadrEVEN[7:2] == 6'd1);
  assign push_odd  = hit_odd  && (st.dataadrODD[7:2]  == 6'd1);

  // A pop this cycle frees its slot for the same edge's pushes. EVEN takes
  // the first free slot; ODD needs one more beyond whatever EVEN took.
  assign free     = DEPTH_C - fifo_count + {{(CW-1){1'b0}}, pop};
  assign acc_even = push_even && (free != '0);
  assign acc_odd  = push_odd  && (free > {{(CW-1){1'b0}}, acc_even});
  assign drop     = (push_even && !acc_even) || (push_odd && !acc_odd);

  // Sequencer decides from the registered occupancy, so a word pushed at
  // an edge is never popped at that same edge.
  always_comb begin
    state_next = state;
    timer_next = timer;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          timer_next = TIMER_RELOAD;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (timer != '0) begin
          timer_next = timer - TW'(1);
        end else if (fifo_count != '0) begin
          pop        = 1'b1;
          timer_next = TIMER_RELOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      ledr       <= '0;
      disp       <= '0;
      disp_valid <= 1'b0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      disp_valid <= (state_next == HOLD);
      if (pop) begin
        disp   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (led_odd)       ledr <= st.writedataODD[15:0];
      else if (led_even) ledr <= st.writedataEVEN[15:0];
      wr_ptr     <= wr_ptr + PW'(acc_even) + PW'(acc_odd);
      fifo_count <= fifo_count + CW'(acc_even) + CW'(acc_odd) - CW'(pop);
      if (drop)         overflow <= 1'b1;
      else if (ack_ovf) overflow <= 1'b0;
    end
  end

  // Storage array has no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (reset && acc_even) mem[wr_ptr] <= st.writedataEVEN[15:0];
    if (reset && acc_odd)  mem[wr_ptr + PW'(acc_even)] <= st.writedataODD[15:0];
  end

endmodule

// File: doc/mmio_store_monitor.md
Name: mmio_store_monitor

Overview:
- Downstream consumer of the dual-lane (EVEN/ODD) store port of the superscalar pipeline top level.
- Snoops both lanes' data-memory writes every clock and decodes stores that fall in a memory-mapped I/O page.
- Drives a 16-bit LED register, and queues display words into a small FIFO.
- A display sequencer holds each queued word on a 16-bit output for a programmable number of clocks, so program output is human-visible on the board.

Parameters:
- IO_PAGE, 16'hFFFF, value of dataadr[31:16] that selects the I/O page.
- DEPTH, 8, display FIFO entries; power of 2, minimum 2.
- HOLD_CYCLES, 4, clocks each display word is held; minimum 1.

Ports:
- clk  input  1  processor clock (the divided clk of the top level)
- reset  input  1  asynchronous, active-low; asserted when 0
- memwriteEVEN  input  1  EVEN-lane store strobe (older instruction of the pair)
- dataadrEVEN  input  32  EVEN-lane store byte address
- writedataEVEN  input  32  EVEN-lane store data
- memwriteODD  input  1  ODD-lane store strobe (younger instruction of the pair)
- dataadrODD  input  32  ODD-lane store byte address
- writedataODD  input  32  ODD-lane store data
- ack_ovf  input  1  clears the sticky overflow flag
- ledr  output  16  LED register
- disp  output  16  current display word
- disp_valid  output  1  disp is being actively held
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky; set when a push was dropped

Behaviour:
- Reset (reset==0, asynchronous) clears all outputs:
  - ledr=0, disp=0, disp_valid=0, fifo_count=0, overflow=0.
  - FIFO read/write pointers=0; FSM=IDLE; hold timer=0.
  - Reset asserted mid-hold or mid-push aborts immediately, with no partial update after release.
- Decode, per lane: hit = memwrite && dataadr[31:16]==IO_PAGE. Offset is dataadr[7:0].
  - 0x00: LED write. 0x04: display push.
  - Any other offset, and any address outside the page, is ignored.
  - dataadr[1:0] and dataadr[15:8] are ignored.
- LED register:
  - On a clock edge with a LED hit, ledr <= writedata[15:0].
  - If both lanes hit LED in the same cycle, the ODD lane (younger) wins.
- FIFO push:
  - Push data is writedata[15:0].
  - If both lanes push in the same cycle, EVEN is enqueued first, then ODD. Program order is preserved.
  - Up to 2 pushes and 1 pop per clock.
  - free = DEPTH - fifo_count + (pop this cycle ? 1 : 0).
  - Pushes are accepted in order while free > 0; any excess push is dropped and overflow <= 1.
  - With exactly 1 free slot and two pushes, EVEN is accepted and ODD is dropped.
  - Pointers wrap modulo DEPTH.
  - fifo_count updates by +pushes_accepted - pop at each edge.
- Overflow:
  - Sticky. Cleared when ack_ovf==1 at an edge.
  - If a new drop occurs in the same cycle as ack_ovf, set wins and overflow stays 1.
- Display sequencer FSM, states IDLE and HOLD:
  - IDLE: disp_valid=0; disp keeps its last value. If fifo_count>0 at an edge, pop the head: disp <= head, disp_valid <= 1, timer <= HOLD_CYCLES-1, go to HOLD.
  - HOLD, timer>0: timer decrements.
  - HOLD, timer==0 and fifo_count>0: pop the next word back-to-back with no gap cycle, reload the timer, stay in HOLD.
  - HOLD, timer==0 and FIFO empty: go to IDLE, disp_valid <= 0.
  - Each word is therefore valid for exactly HOLD_CYCLES clocks.
  - The FSM pops using the registered fifo_count. A word pushed at edge k is first displayed at edge k+1 when the FSM is IDLE.
- Simultaneous events:
  - Push into an empty FIFO while IDLE: the word lands at edge k and is popped at edge k+1. There is no push-to-pop bypass.
  - A pop and two pushes with a full FIFO accept exactly one push.
- All state is updated on posedge clk only, apart from reset. Outputs are registered.

Test Plan:
- Reset and idle: hold reset=0 for 3 clocks, then release with no stores -> all outputs 0 for 10 clocks.
- LED write collision: same cycle, EVEN stores 0x1111 and ODD stores 0x2222, both to 0xFFFF0000 -> ledr==0x2222 after the edge. A lone EVEN store to 0x12340000 -> ledr unchanged.
- Ordered dual push: with HOLD_CYCLES=4, in one cycle EVEN pushes 0xAAAA and ODD pushes 0xBBBB to 0xFFFF0004 -> fifo_count=2 at edge k, disp=0xAAAA valid at edges k+1..k+4, disp=0xBBBB at k+5..k+8, disp_valid=0 from k+9.
- Overflow boundary: with DEPTH=8, fill to 7 with the sequencer stalled mid-hold (no pop that cycle), then dual push 0x0007/0x0008 -> 0x0007 accepted, 0x0008 dropped, fifo_count=8, overflow=1.
- Overflow clear: pulse ack_ovf with no drop that cycle -> overflow=0. Pulse ack_ovf in the same cycle as a new drop -> overflow stays 1.
- Reset mid-hold: assert reset while disp_valid=1 and fifo_count=3 -> disp, disp_valid and fifo_count are 0 immediately. After release, no stale word is ever displayed.
